// File: rtl/div_unit_if.sv
// div_unit_if: EX->divider request and divider->MEM response bundle.
// master: request side (req_valid, src1, src2, div_op, cancel, resp_ready)
// slave : divider side (req_ready, resp_valid, result, busy)
interface div_unit_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       div_op;
  logic             cancel;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
  modport master (
    output req_valid, src1, src2, div_op, cancel, resp_ready,
    input  req_ready, resp_valid, result, busy
  );
  modport slave (
    input  req_valid, src1, src2, div_op, cancel, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu).
// Ports: clk (rising edge), resetn (async active-low), bus (div_unit_if.slave:
//   req_valid/req_ready/src1/src2/div_op/cancel in, resp_valid/resp_ready/result/busy).
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero or |src1| < |src2| skips the
//   iterations and completes one cycle after the handshake; results are identical.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_qsign, r_rsign, r_mod, r_skip;
  logic             w_fire, w_signed, w_mod, w_s1, w_s2, w_early;
  logic [WIDTH-1:0] w_a, w_b, w_quo, w_rem;
  logic [WIDTH:0]   w_shift, w_diff;
  assign w_fire   = bus.req_valid && bus.req_ready;
  assign w_signed = |(bus.div_op & 4'b0011);
  assign w_mod    = |(bus.div_op & 4'b1010);
  assign w_s1     = w_signed & bus.src1[WIDTH-1];
  assign w_s2     = w_signed & bus.src2[WIDTH-1];
  assign w_a      = w_s1 ? -bus.src1 : bus.src1;
  assign w_b      = w_s2 ? -bus.src2 : bus.src2;
`ifdef DIV_EARLY_OUT_EN
  assign w_early  = (w_b == '0) || (w_a < w_b);
`else
  assign w_early  = 1'b0;
`endif
  // r_quo starts as the dividend and shifts out MSB-first while quotient bits shift in
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_quo    = r_qsign ? -r_quo : r_quo;
  assign w_rem    = r_rsign ? -r_rem : r_rem;
  assign bus.req_ready  = resetn && (r_state == IDLE) && !bus.cancel;
  assign bus.resp_valid = (r_state == DONE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.result     = bus.resp_valid ? (r_mod ? w_rem : w_quo) : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fire ? CALC : IDLE;
      CALC:    w_next = bus.cancel ? IDLE : (r_cnt == CW'(WIDTH - 1)) ? DONE : CALC;
      DONE:    w_next = (bus.cancel || bus.resp_ready) ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_mod   <= 1'b0;
      r_skip  <= 1'b0;
    end else if (w_fire) begin
      // early-out preloads the final magnitudes and jumps the counter to its last step
      r_cnt   <= w_early ? CW'(WIDTH - 1) : '0;
      r_rem   <= w_early ? w_a : '0;
      r_quo   <= w_early ? ((w_b == '0) ? '1 : '0) : w_a;
      r_dvs   <= w_b;
      // divide by zero keeps the all-ones quotient unsigned-looking for signed ops too
      r_qsign <= (w_s1 ^ w_s2) && (w_b != '0);
      r_rsign <= w_s1;
      r_mod   <= w_mod;
      r_skip  <= w_early;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_skip) begin
        r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against a plain-arithmetic model.
module tb_div_unit;
  localparam logic [3:0] DIVW = 4'b0001, MODW = 4'b0010, DIVWU = 4'b0100, MODWU = 4'b1000;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  div_unit_if #(.WIDTH(32)) bus();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (op[0] | op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return (op[1] | op[3]) ? r : q;
  endfunction
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    ma = ((op[0] | op[1]) && a[31]) ? -a : a;
    mb = ((op[0] | op[1]) && b[31]) ? -b : b;
    return (mb == 0 || ma < mb) ? 2 : 33;
`else
    return 33;
`endif
  endfunction
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.src1 = a;
    bus.src2 = b;
    bus.div_op = op;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.src1 = $urandom;
    bus.src2 = $urandom;
    bus.div_op = 4'b1 << $urandom_range(0, 3);
    check("accept", {31'd0, bus.busy}, 32'd1);
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.resp_valid) return;
      lat++;
    end
    check("timeout", 32'd0, 32'd1);
  endtask
  task automatic consume();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check("idle_after", {31'd0, bus.req_ready}, 32'd1);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic [31:0] exp);
    int lat;
    start(a, b, op);
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat(a, b, op));
    check(tag, bus.result, exp);
    consume();
  endtask
  initial begin
    int lat;
    logic seen;
    logic [31:0] a, b;
    logic [3:0] op;
    bus.req_valid = 1'b0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.div_op = DIVW;
    bus.cancel = 1'b0;
    bus.resp_ready = 1'b0;
    #2;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    run("divw_100_7", 32'd100, 32'd7, DIVW, 32'd14);
    run("modw_100_7", 32'd100, 32'd7, MODW, 32'd2);
    run("divw_m7_2", 32'hFFFF_FFF9, 32'd2, DIVW, 32'hFFFF_FFFD);
    run("modw_m7_2", 32'hFFFF_FFF9, 32'd2, MODW, 32'hFFFF_FFFF);
    run("divwu_big_2", 32'hFFFF_FFF9, 32'd2, DIVWU, 32'h7FFF_FFFC);
    run("divwu_5_0", 32'd5, 32'd0, DIVWU, 32'hFFFF_FFFF);
    run("modwu_5_0", 32'd5, 32'd0, MODWU, 32'd5);
    run("divw_m5_0", 32'hFFFF_FFFB, 32'd0, DIVW, 32'hFFFF_FFFF);
    run("modw_m5_0", 32'hFFFF_FFFB, 32'd0, MODW, 32'hFFFF_FFFB);
    run("divw_ovf", 32'h8000_0000, 32'hFFFF_FFFF, DIVW, 32'h8000_0000);
    run("modw_ovf", 32'h8000_0000, 32'hFFFF_FFFF, MODW, 32'd0);
    run("divw_3_10", 32'd3, 32'd10, DIVW, 32'd0);
    run("modw_3_10", 32'd3, 32'd10, MODW, 32'd3);
    // backpressure: result held while MEM stalls
    start(32'd1000, 32'd7, DIVWU);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hold_result", bus.result, 32'd142);
      check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    consume();
    // cancel mid-calculation
    start(32'd1000, 32'd3, DIVWU);
    repeat (14) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    check("cancel_no_resp", {31'd0, seen}, 32'd0);
    run("after_cancel_9_3", 32'd9, 32'd3, DIVW, 32'd3);
    // cancel in IDLE blocks acceptance
    @(negedge clk);
    bus.cancel = 1'b1;
    bus.req_valid = 1'b1;
    bus.src1 = 32'd50;
    bus.src2 = 32'd5;
    bus.div_op = DIVW;
    #1;
    check("idle_cancel_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    bus.req_valid = 1'b0;
    check("idle_cancel_busy", {31'd0, bus.busy}, 32'd0);
    // cancel beats resp_ready in DONE
    start(32'd9, 32'd3, DIVW);
    wait_valid(lat);
    bus.cancel = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    bus.resp_ready = 1'b0;
    check("done_cancel_busy", {31'd0, bus.busy}, 32'd0);
    check("done_cancel_valid", {31'd0, bus.resp_valid}, 32'd0);
    // asynchronous reset mid-calculation
    start(32'd1000, 32'd3, DIVWU);
    repeat (10) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    check("arst_no_resp", {31'd0, seen}, 32'd0);
    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = 4'b1 << $urandom_range(0, 3);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
      run("rand", a, b, op, model(a, b, op));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider and the responder for the EX-stage divide request handshake.
- Accepts one request (operands + op) per transaction from EX and computes for 32 cycles.
- Holds the quotient or remainder result on a valid/ready response port consumed by the MEM stage.
- Flushes (exception, ertn, tlb refetch) abort the transaction in flight.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  EX request valid (driven by to_div_req_valid)
- req_ready  output  1  unit can accept a request
- src1  input  WIDTH  dividend (rj)
- src2  input  WIDTH  divisor (rk)
- div_op  input  4  one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu
- cancel  input  1  pipeline flush; aborts any transaction
- resp_valid  output  1  result available
- resp_ready  input  1  MEM stage consumes result
- result  output  WIDTH  quotient (div) or remainder (mod)
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, CALC, DONE. resetn low forces IDLE asynchronously.
- Reset values: req_ready=1 after deassertion (0 while resetn low), resp_valid=0, result=0, busy=0, iteration counter=0.
- req_ready = (state==IDLE) && !cancel. Handshake = req_valid && req_ready.
- Handshake at edge T:
  - capture |src1|, |src2| (absolute values when signed op, raw when unsigned), quotient sign = s1^s2, remainder sign = s1, op select.
  - state -> CALC, counter=0.
- CALC, each edge:
  - shift partial remainder left by one, bringing in the next dividend bit MSB-first.
  - trial subtract divisor; if non-negative, keep the difference and set the quotient bit.
  - counter++.
  - At the edge where counter==WIDTH-1 (edge T+WIDTH): state -> DONE.
- DONE:
  - resp_valid=1; result = sign-corrected quotient or remainder per captured op; stable until consumed.
  - resp_valid && resp_ready at an edge -> IDLE.
  - No same-cycle acceptance of a new request; the earliest next handshake is the following edge.
- Latency: handshake at edge T -> resp_valid high in the cycle after edge T+32 (WIDTH=32).
- Sign correction: negate quotient if the quotient sign is 1; negate remainder if the dividend was negative. Arithmetic is mod 2^WIDTH.
- Divide by zero (no exception): quotient = all ones (0xFFFFFFFF) for both signed and unsigned ops; remainder = src1 unchanged. Produced by the normal iteration, with no special-case timing.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- cancel:
  - in CALC or DONE: state -> IDLE at the next edge; resp_valid falls; result discarded.
  - in IDLE: blocks acceptance that cycle.
  - cancel and resp_ready together in DONE: cancel wins; state -> IDLE either way.
- resetn asserted mid-CALC: immediate IDLE; no response is ever produced for that request.
- Operands are sampled only at the handshake; src1, src2 and div_op are don't-care afterwards.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at the handshake, if the divisor is zero, or |dividend| < |divisor| (unsigned compare of magnitudes), the unit goes straight to DONE.
  - Quotient is 0, or all ones for divide by zero.
  - Remainder is the dividend, sign-corrected.
  - resp_valid is high in the cycle after edge T+1.
- Undefined: every request takes the full WIDTH iterations.
- Results are identical in both builds; only latency differs.

Test Plan:
- div.w 100 / 7 -> resp_valid after 33 cycles, result 14. Same operands with mod.w -> 2.
- div.w -7 / 2 -> 0xFFFFFFFD (-3). mod.w -7 / 2 -> 0xFFFFFFFF (-1). div.wu 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- div.wu 5 / 0 -> 0xFFFFFFFF; mod.wu 5 / 0 -> 5; div.w 0x80000000 / -1 -> 0x80000000, mod -> 0.
- Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and result stable, req_ready=0. Raise resp_ready -> IDLE next edge, req_ready=1.
- Assert cancel at iteration 15 -> IDLE next edge, no resp_valid pulse. Immediate new request 9/3 -> result 3 with full latency.
- Drop resetn mid-CALC -> outputs 0 asynchronously. With DIV_EARLY_OUT_EN, 3 / 10 -> resp_valid after 2 cycles, quotient 0, mod.w result 3.
